// File: rtl/goods_pkg.sv
// Shared types and default key codes for the goods cart selector.
package goods_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SELECT   = 2'd1,
    DISPENSE = 2'd2
  } state_t;

  localparam int DEF_KEY_W        = 5;
  localparam int DEF_QTY_W        = 3;
  localparam int DEF_CODE_CONFIRM = 17;
  localparam int DEF_CODE_CANCEL  = 18;
  localparam int DEF_CODE_DELETE  = 19;

  // One cart slot at the default key and quantity widths.
  typedef struct packed {
    logic [DEF_KEY_W-1:0] index;
    logic [DEF_QTY_W-1:0] qty;
  } cart_entry_t;

endpackage

// File: rtl/goods_cart_regs.sv
// Cart register file: append, increment, delete-last, clear and read-by-pointer.
// GOODS_CART_MERGE_EN widens the match from the last entry to every occupied entry.
module goods_cart_regs #(
  parameter int KEY_W      = 5,
  parameter int QTY_W      = 3,
  parameter int CART_DEPTH = 4,
  parameter int CNT_W      = $clog2(CART_DEPTH + 1),
  parameter int PTR_W      = (CART_DEPTH > 1) ? $clog2(CART_DEPTH) : 1
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             clr,
  input  logic             append,
  input  logic             inc,
  input  logic             del,
  input  logic [KEY_W-1:0] key_index,
  input  logic [PTR_W-1:0] inc_slot,
  input  logic [PTR_W-1:0] rd_ptr,
  output logic [CNT_W-1:0] cnt,
  output logic             full,
  output logic             match_hit,
  output logic             match_sat,
  output logic [PTR_W-1:0] match_slot,
  output logic [KEY_W-1:0] prev_index,
  output logic [KEY_W-1:0] rd_index,
  output logic [QTY_W-1:0] rd_qty
);

  logic [KEY_W-1:0] idx_q [CART_DEPTH];
  logic [QTY_W-1:0] qty_q [CART_DEPTH];
  logic [CNT_W-1:0] cnt_q;
  logic [PTR_W-1:0] last_slot;

  assign last_slot = PTR_W'(cnt_q - 1'b1);
  assign cnt       = cnt_q;
  assign full      = (cnt_q == CNT_W'(CART_DEPTH));
  assign rd_index  = idx_q[rd_ptr];
  assign rd_qty    = qty_q[rd_ptr];

  // Index of the entry that becomes last after a delete.
  assign prev_index = (cnt_q > CNT_W'(1)) ? idx_q[PTR_W'(cnt_q - CNT_W'(2))] : '0;

  always_comb begin
    // NOTE: every combinational output gets a default first so no latch is inferred.
    match_hit  = 1'b0;
    match_slot = '0;
`ifdef GOODS_CART_MERGE_EN
    // Scan downwards so the lowest matching slot is the one left standing.
    for (int i = CART_DEPTH - 1; i >= 0; i--) begin
      if (i < int'(cnt_q) && idx_q[i] == key_index) begin
        match_hit  = 1'b1;
        match_slot = PTR_W'(i);
      end
    end
`else
    if (cnt_q != '0 && idx_q[last_slot] == key_index) begin
      match_hit  = 1'b1;
      match_slot = last_slot;
    end
`endif
    match_sat = &qty_q[match_slot];
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      // NOTE: the slots are reset too; it is only a handful of flops and keeps read data defined.
      cnt_q <= '0;
      for (int i = 0; i < CART_DEPTH; i++) begin
        idx_q[i] <= '0;
        qty_q[i] <= '0;
      end
    end else if (clr) begin
      cnt_q <= '0;
    end else if (append) begin
      // NOTE: sequential state uses non-blocking assignments so all flops update together.
      idx_q[PTR_W'(cnt_q)] <= key_index;
      qty_q[PTR_W'(cnt_q)] <= QTY_W'(1);
      cnt_q                <= cnt_q + 1'b1;
    end else if (inc) begin
      qty_q[inc_slot] <= qty_q[inc_slot] + 1'b1;
    end else if (del) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

endmodule

// File: rtl/goods_cart_select.sv
// Keypad cart builder with confirm/cancel/delete, inactivity timeout and dispense streaming.
// Optional GOODS_CART_MERGE_EN: repeated goods merge into any matching entry.
module goods_cart_select
  import goods_pkg::*;
#(
  parameter int KEY_W        = DEF_KEY_W,
  parameter int N_GOODS      = 12,
  parameter int CODE_CONFIRM = DEF_CODE_CONFIRM,
  parameter int CODE_CANCEL  = DEF_CODE_CANCEL,
  parameter int CODE_DELETE  = DEF_CODE_DELETE,
  parameter int CART_DEPTH   = 4,
  parameter int QTY_W        = DEF_QTY_W,
  parameter int TIMEOUT_CYC  = 1000000
) (
  input  logic                              clk,
  input  logic                              rstn,
  input  logic [KEY_W-1:0]                  key_code,
  input  logic                              key_valid,
  input  logic                              enough_flag,
  output logic [KEY_W-1:0]                  sel_index,
  output logic [$clog2(CART_DEPTH+1)-1:0]   cart_cnt,
  output logic                              busy,
  output logic                              err_pulse,
  output logic                              timeout_pulse,
  output logic                              disp_valid,
  input  logic                              disp_ready,
  output logic [KEY_W-1:0]                  disp_index,
  output logic [QTY_W-1:0]                  disp_qty,
  output logic                              done_pulse
);

  localparam int  CNT_W  = $clog2(CART_DEPTH + 1);
  localparam int  PTR_W  = (CART_DEPTH > 1) ? $clog2(CART_DEPTH) : 1;
  localparam int  TMR_W  = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam bit  TMO_EN = (TIMEOUT_CYC != 0);

  state_t           state_q, state_d;
  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic [TMR_W-1:0] tmr_q, tmr_d;
  logic [KEY_W-1:0] sel_q, sel_d;
  logic             err_d, tmo_d, done_d;
  logic             clr, append, inc, del;
  logic [CNT_W-1:0] cnt;
  logic             full, match_hit, match_sat;
  logic [PTR_W-1:0] match_slot;
  logic [KEY_W-1:0] prev_index, rd_index;
  logic [QTY_W-1:0] rd_qty;
  logic             is_goods;

  goods_cart_regs #(
    .KEY_W(KEY_W), .QTY_W(QTY_W), .CART_DEPTH(CART_DEPTH), .CNT_W(CNT_W), .PTR_W(PTR_W)
  ) u_regs (
    .clk(clk), .rstn(rstn), .clr(clr), .append(append), .inc(inc), .del(del),
    .key_index(key_code), .inc_slot(match_slot), .rd_ptr(ptr_q),
    .cnt(cnt), .full(full), .match_hit(match_hit), .match_sat(match_sat),
    .match_slot(match_slot), .prev_index(prev_index), .rd_index(rd_index), .rd_qty(rd_qty)
  );

  assign is_goods = (int'(key_code) >= 1) && (int'(key_code) <= N_GOODS);

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    tmr_d   = '0;
    sel_d   = sel_q;
    err_d   = 1'b0;
    tmo_d   = 1'b0;
    done_d  = 1'b0;
    clr     = 1'b0;
    append  = 1'b0;
    inc     = 1'b0;
    del     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (key_valid && is_goods) begin
          append  = 1'b1;
          sel_d   = key_code;
          state_d = SELECT;
        end
      end
      SELECT: begin
        if (TMO_EN) tmr_d = tmr_q + 1'b1;
        if (key_valid) begin
          tmr_d = '0;
          if (is_goods) begin
            if (match_hit) begin
              if (match_sat) err_d = 1'b1;
              else begin
                inc   = 1'b1;
                sel_d = key_code;
              end
            end else if (!full) begin
              append = 1'b1;
              sel_d  = key_code;
            end else begin
              err_d = 1'b1;
            end
          end else if (int'(key_code) == CODE_DELETE) begin
            del   = 1'b1;
            sel_d = prev_index;
            if (cnt == CNT_W'(1)) state_d = IDLE;
          end else if (int'(key_code) == CODE_CANCEL) begin
            clr     = 1'b1;
            sel_d   = '0;
            state_d = IDLE;
          end else if (int'(key_code) == CODE_CONFIRM) begin
            if (enough_flag) begin
              ptr_d   = '0;
              state_d = DISPENSE;
            end else begin
              err_d = 1'b1;
            end
          end
        end else if (TMO_EN && tmr_q == TMR_W'(TIMEOUT_CYC - 1)) begin
          tmr_d   = '0;
          clr     = 1'b1;
          sel_d   = '0;
          tmo_d   = 1'b1;
          state_d = IDLE;
        end
      end
      DISPENSE: begin
        if (disp_ready) begin
          if (CNT_W'(ptr_q) == cnt - 1'b1) begin
            clr     = 1'b1;
            sel_d   = '0;
            done_d  = 1'b1;
            state_d = IDLE;
          end else begin
            ptr_d = ptr_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q       <= IDLE;
      ptr_q         <= '0;
      tmr_q         <= '0;
      sel_q         <= '0;
      err_pulse     <= 1'b0;
      timeout_pulse <= 1'b0;
      done_pulse    <= 1'b0;
    end else begin
      state_q       <= state_d;
      ptr_q         <= ptr_d;
      tmr_q         <= tmr_d;
      sel_q         <= sel_d;
      err_pulse     <= err_d;
      timeout_pulse <= tmo_d;
      done_pulse    <= done_d;
    end
  end

  // Entry data is gated so stale slots never show outside DISPENSE.
  assign disp_valid = (state_q == DISPENSE);
  assign disp_index = disp_valid ? rd_index : '0;
  assign disp_qty   = disp_valid ? rd_qty : '0;
  assign busy       = (state_q != IDLE);
  assign sel_index  = sel_q;
  assign cart_cnt   = cnt;

endmodule

// File: tb/tb_goods_cart_select.sv
// Scoreboard bench for goods_cart_select: a cart model predicts key effects and dispense entries.
module tb_goods_cart_select;
  import goods_pkg::*;

  localparam int KEY_W = 5, QTY_W = 3, DEPTH = 4, TMO = 10;
  localparam int K_CONFIRM = 17, K_CANCEL = 18, K_DELETE = 19;

  logic             clk = 1'b0;
  logic             rstn = 1'b0;
  logic [KEY_W-1:0] key_code = '0;
  logic             key_valid = 1'b0;
  logic             enough_flag = 1'b0;
  logic             disp_ready = 1'b0;
  logic [KEY_W-1:0] sel_index, disp_index;
  logic [2:0]       cart_cnt;
  logic             busy, err_pulse, timeout_pulse, disp_valid, done_pulse;
  logic [QTY_W-1:0] disp_qty;

  goods_cart_select #(
    .KEY_W(KEY_W), .N_GOODS(12), .CODE_CONFIRM(K_CONFIRM), .CODE_CANCEL(K_CANCEL),
    .CODE_DELETE(K_DELETE), .CART_DEPTH(DEPTH), .QTY_W(QTY_W), .TIMEOUT_CYC(TMO)
  ) dut (
    .clk(clk), .rstn(rstn), .key_code(key_code), .key_valid(key_valid),
    .enough_flag(enough_flag), .sel_index(sel_index), .cart_cnt(cart_cnt), .busy(busy),
    .err_pulse(err_pulse), .timeout_pulse(timeout_pulse), .disp_valid(disp_valid),
    .disp_ready(disp_ready), .disp_index(disp_index), .disp_qty(disp_qty),
    .done_pulse(done_pulse)
  );

  always #5 clk = ~clk;

  int          total = 0;
  int          bad = 0;
  cart_entry_t m_cart[$];
  cart_entry_t exp_q[$];
  state_t      m_state = IDLE;
  int          m_sel = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d @%0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit is_goods(input int k);
    return (k >= 1) && (k <= 12);
  endfunction

  // Predict the effect of one key press, drive it, then compare the registered result.
  task automatic press(input int k, input bit enough);
    bit          exp_err = 1'b0;
    int          slot = -1;
    cart_entry_t e;
    case (m_state)
      IDLE: if (is_goods(k)) begin
        e.index = KEY_W'(k); e.qty = QTY_W'(1);
        m_cart.push_back(e);
        m_sel = k;
        m_state = SELECT;
      end
      SELECT: begin
        if (is_goods(k)) begin
`ifdef GOODS_CART_MERGE_EN
          for (int i = 0; i < m_cart.size(); i++)
            if (slot < 0 && int'(m_cart[i].index) == k) slot = i;
`else
          if (m_cart.size() > 0 && int'(m_cart[m_cart.size()-1].index) == k)
            slot = m_cart.size() - 1;
`endif
          if (slot >= 0) begin
            e = m_cart[slot];
            if (int'(e.qty) == 7) exp_err = 1'b1;
            else begin
              e.qty = e.qty + QTY_W'(1);
              m_cart[slot] = e;
              m_sel = k;
            end
          end else if (m_cart.size() < DEPTH) begin
            e.index = KEY_W'(k); e.qty = QTY_W'(1);
            m_cart.push_back(e);
            m_sel = k;
          end else exp_err = 1'b1;
        end else if (k == K_DELETE) begin
          void'(m_cart.pop_back());
          m_sel = (m_cart.size() > 0) ? int'(m_cart[m_cart.size()-1].index) : 0;
          if (m_cart.size() == 0) m_state = IDLE;
        end else if (k == K_CANCEL) begin
          m_cart.delete();
          m_sel = 0;
          m_state = IDLE;
        end else if (k == K_CONFIRM) begin
          if (enough) begin
            foreach (m_cart[i]) exp_q.push_back(m_cart[i]);
            m_state = DISPENSE;
          end else exp_err = 1'b1;
        end
      end
      default: ;
    endcase
    @(negedge clk);
    key_code    = KEY_W'(k);
    enough_flag = enough;
    key_valid   = 1'b1;
    @(negedge clk);
    key_valid = 1'b0;
    key_code  = '0;
    check($sformatf("err k=%0d", k), err_pulse, exp_err);
    check($sformatf("cnt k=%0d", k), cart_cnt, m_cart.size());
    check($sformatf("sel k=%0d", k), sel_index, m_sel);
    check($sformatf("busy k=%0d", k), busy, m_state != IDLE);
    check($sformatf("dvalid k=%0d", k), disp_valid, m_state == DISPENSE);
    check($sformatf("tmo k=%0d", k), timeout_pulse, 0);
  endtask

  // Pop and compare scoreboard entries as the DUT offers them; disp_ready low for 'stall' cycles.
  task automatic drain(input int stall);
    bit finished = 1'b0;
    int c = 0;
    while (!finished && c < 40) begin
      @(negedge clk);
      disp_ready = (c >= stall);
      c++;
      check("disp_valid", disp_valid, 1);
      check("done_early", done_pulse, 0);
      if (exp_q.size() > 0) begin
        check("disp_index", disp_index, exp_q[0].index);
        check("disp_qty", disp_qty, exp_q[0].qty);
      end
      if (disp_ready && disp_valid) begin
        void'(exp_q.pop_front());
        if (exp_q.size() == 0) begin
          @(negedge clk);
          disp_ready = 1'b0;
          check("done_pulse", done_pulse, 1);
          check("valid_end", disp_valid, 0);
          check("cnt_end", cart_cnt, 0);
          check("sel_end", sel_index, 0);
          check("busy_end", busy, 0);
          m_cart.delete();
          m_sel = 0;
          m_state = IDLE;
          finished = 1'b1;
        end
      end
    end
    if (!finished) begin
      check("drain_budget", 0, 1);
      disp_ready = 1'b0;
      exp_q.delete();
    end
  endtask

  // After a key at posedge P0, timeout_pulse must be high exactly after posedge P0+TMO.
  task automatic expect_timeout();
    for (int c = 1; c <= TMO; c++) begin
      @(negedge clk);
      check($sformatf("tmo c=%0d", c), timeout_pulse, c == TMO);
    end
    check("tmo_cnt", cart_cnt, 0);
    check("tmo_busy", busy, 0);
    check("tmo_sel", sel_index, 0);
    m_cart.delete();
    m_sel = 0;
    m_state = IDLE;
  endtask

  initial begin
    #3;
    check("rst_sel", sel_index, 0);
    check("rst_cnt", cart_cnt, 0);
    check("rst_busy", busy, 0);
    check("rst_err", err_pulse, 0);
    check("rst_tmo", timeout_pulse, 0);
    check("rst_dvalid", disp_valid, 0);
    check("rst_didx", disp_index, 0);
    check("rst_dqty", disp_qty, 0);
    check("rst_done", done_pulse, 0);
    @(negedge clk);
    rstn = 1'b1;

    // Non-goods key in IDLE is ignored without error.
    press(K_CONFIRM, 1'b1);

    // Adjacent repeat merges; stream at full rate.
    press(3, 1'b0); press(3, 1'b0); press(5, 1'b0); press(K_CONFIRM, 1'b1);
    drain(0);

    // Full cart rejects, delete then re-add; keys ignored mid-dispense; stalled handshake.
    press(1, 1'b0); press(2, 1'b0); press(3, 1'b0); press(4, 1'b0);
    press(6, 1'b0); press(K_DELETE, 1'b0); press(6, 1'b0);
    press(K_CONFIRM, 1'b1);
    press(K_CANCEL, 1'b0); press(4, 1'b0);
    drain(5);

    // Quantity saturation, confirm without payment, then dispense (7,7).
    for (int i = 0; i < 8; i++) press(7, 1'b0);
    press(K_CONFIRM, 1'b0);
    press(K_CONFIRM, 1'b1);
    drain(0);

    // Delete down to empty returns to IDLE; cancel clears.
    press(8, 1'b0); press(9, 1'b0); press(K_DELETE, 1'b0); press(K_DELETE, 1'b0);
    press(10, 1'b0); press(K_CANCEL, 1'b0);

    // Timeout fires; a key on the expiry cycle suppresses it and restarts the count.
    press(2, 1'b0);
    expect_timeout();
    press(2, 1'b0);
    repeat (TMO - 1) @(negedge clk);
    key_code  = '0;
    key_valid = 1'b1;
    @(negedge clk);
    key_valid = 1'b0;
    check("tmo_suppressed", timeout_pulse, 0);
    check("tmo_keep_cnt", cart_cnt, 1);
    expect_timeout();

    // Non-adjacent repeat: merged or separate depending on the build.
    press(3, 1'b0); press(5, 1'b0); press(3, 1'b0); press(K_CONFIRM, 1'b1);
    drain(0);

    // Reset in the middle of a dispense abandons it at once.
    press(1, 1'b0); press(2, 1'b0); press(K_CONFIRM, 1'b1);
    disp_ready = 1'b1;
    @(negedge clk);
    disp_ready = 1'b0;
    #2 rstn = 1'b0;
    #1;
    check("mid_rst_dvalid", disp_valid, 0);
    check("mid_rst_didx", disp_index, 0);
    check("mid_rst_dqty", disp_qty, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_cnt", cart_cnt, 0);
    check("mid_rst_sel", sel_index, 0);
    exp_q.delete();
    m_cart.delete();
    m_sel = 0;
    m_state = IDLE;
    @(negedge clk);
    rstn = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("mid_rst_no_done", done_pulse, 0);
    end
    press(11, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/goods_cart_select.md
Name: goods_cart_select

Overview:
- Parametrised successor to the single-item goods selector in the vending-machine keypad path.
- Accepts keypad codes, builds a cart of up to CART_DEPTH (index, quantity) entries, and supports confirm, cancel, delete-last and inactivity timeout.
- After payment is confirmed, streams the cart entries to the dispenser over a valid/ready handshake.
- Sits between the keypad decoder and the dispense controller; enough_flag comes from the coin/payment block.

Parameters:
- KEY_W, 5: keypad code width.
- N_GOODS, 12: valid goods codes are 1..N_GOODS.
- CODE_CONFIRM, 17: confirm key code.
- CODE_CANCEL, 18: cancel key code.
- CODE_DELETE, 19: delete-last-entry key code.
- CART_DEPTH, 4: maximum number of cart entries (≥1).
- QTY_W, 3: per-entry quantity width; quantity saturates at 2^QTY_W-1.
- TIMEOUT_CYC, 1000000: cycles without a key in SELECT before the cart is cleared; 0 disables the timeout.

Ports:
- clk  in  1  clock
- rstn  in  1  reset, asynchronous, active-low
- key_code  in  KEY_W  keypad code, qualified by key_valid
- key_valid  in  1  one-cycle strobe per key press
- enough_flag  in  1  payment covers the cart (level)
- sel_index  out  KEY_W  goods index of the most recently added or incremented entry; 0 when cart empty
- cart_cnt  out  $clog2(CART_DEPTH+1)  number of occupied entries
- busy  out  1  high in SELECT or DISPENSE
- err_pulse  out  1  one-cycle pulse on a rejected key
- timeout_pulse  out  1  one-cycle pulse when the timeout fires
- disp_valid  out  1  dispense entry valid
- disp_ready  in  1  dispenser accepts the entry
- disp_index  out  KEY_W  goods index of the presented entry
- disp_qty  out  QTY_W  quantity of the presented entry
- done_pulse  out  1  one-cycle pulse after the last entry is accepted

Behaviour:
- Reset values: all outputs 0, state IDLE, cart empty, timer 0.
- States: IDLE, SELECT, DISPENSE.
- Key events are acted on only when key_valid=1. Registered effect is visible the cycle after the strobe.

IDLE:
- Goods key g (1..N_GOODS): entry0 = (g, 1), cart_cnt=1, go to SELECT.
- Any other code: ignored, no error pulse.

SELECT, goods key g:
- If g equals the last entry's index: that entry's qty += 1. At max, qty holds and err_pulse fires.
- Else, if cart_cnt < CART_DEPTH: append (g, 1).
- Else (cart full): err_pulse, cart unchanged.
- sel_index = g on every successful add or increment.

SELECT, other keys:
- CODE_DELETE: remove the last entry. If cart_cnt becomes 0, go to IDLE. sel_index becomes the new last entry's index, or 0 when empty.
- CODE_CANCEL: clear the cart, go to IDLE.
- CODE_CONFIRM with enough_flag=1 (cart_cnt ≥1 by construction): go to DISPENSE with entry pointer at 0.
- CODE_CONFIRM with enough_flag=0: err_pulse, stay in SELECT.
- Code 0 or any unlisted code: ignored, but still restarts the timer.

Timeout (SELECT only):
- Timer counts every cycle and is cleared by any key_valid.
- When TIMEOUT_CYC≠0 and timer reaches TIMEOUT_CYC-1 with no key that cycle: clear cart, go to IDLE, pulse timeout_pulse.
- If a key arrives on the expiry cycle, the key wins and the timeout does not fire.

DISPENSE:
- disp_valid=1; disp_index/disp_qty show the entry at the pointer and hold stable until disp_valid & disp_ready.
- On each accept the pointer advances.
- On accept of entry cart_cnt-1: disp_valid drops next cycle, done_pulse, cart cleared, go to IDLE.
- All keys are ignored in DISPENSE (no err_pulse). enough_flag is not re-checked.
- disp_ready held high streams one entry per cycle.

General:
- Async reset mid-DISPENSE abandons remaining entries; no done_pulse.

Optional Feature:
- Macro GOODS_CART_MERGE_EN.
- Defined: a goods key matching any existing entry increments that entry's qty (lowest matching slot), saturating with err_pulse. sel_index shows that index. A new slot is used only if no match exists.
- Undefined: only the last entry is merged, as described above; a non-adjacent repeat creates a new entry.

Decomposition:
- Package goods_pkg holds:
  - state enum (IDLE/SELECT/DISPENSE);
  - default key-code constants (CODE_CONFIRM/CANCEL/DELETE);
  - typedef cart_entry_t {index, qty}.
- One natural sub-module, goods_cart_regs: the CART_DEPTH-entry register file with append, increment, delete-last, clear and read-by-pointer ports, plus merge match logic under the macro.
- FSM, timer and handshake stay in goods_cart_select.

Test Plan:
- Keys 3, 3, 5 then CONFIRM with enough_flag=1, disp_ready=1: disp entries (3,2), (5,1) on consecutive cycles, then done_pulse, cart_cnt=0.
- Depth 4 full (1, 2, 3, 4), then key 6: err_pulse, cart_cnt stays 4. Then DELETE, 6: last entry is (6,1).
- Key 7 pressed 8 times with QTY_W=3: qty=7, err_pulse on the 8th press. CONFIRM with enough_flag=0: err_pulse, state stays SELECT.
- TIMEOUT_CYC=10, key 2, then no keys: timeout_pulse exactly 10 cycles after the key, cart_cnt=0. A key on cycle 9 suppresses the timeout.
- DISPENSE with disp_ready low 5 cycles: disp_index/disp_qty stable. Keys CANCEL and 4 mid-dispense are ignored. rstn low mid-dispense: all outputs 0 immediately.
- GOODS_CART_MERGE_EN: keys 3, 5, 3 give entries (3,2), (5,1). Without the macro: (3,1), (5,1), (3,1).
